// File: rtl/fifo_drain_pkg.sv
// Shared types and default sizing for the FIFO read-side transmit drain.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    BUSY    = 2'b10
  } drain_state_t;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/fifo_tx_drain_if.sv
// FIFO read port plus transmitter valid/busy handshake, r_clk domain.
// master = drain side, slave = FIFO/transmitter environment.
interface fifo_tx_drain_if
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  r_inc;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_busy;

  modport master (
    input  rempty,
    input  rdata,
    input  tx_busy,
    output r_inc,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output rempty,
    output rdata,
    output tx_busy,
    input  r_inc,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/drain_timer.sv
// Acceptance timer: clear on word presentation, count enabled cycles, saturate.
// expired is high while the count sits on the last cycle before LIMIT is reached.
module drain_timer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic r_clk,
  input  logic rrst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   TW   = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/fifo_tx_drain.sv
// Pops one FIFO word at a time and offers it to the serial transmitter; 1 cycle pop-to-valid, all outputs registered.
// Next pop waits for tx_busy to fall; optional acceptance timeout under DRAIN_TIMEOUT_EN.
module fifo_tx_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 r_clk,
  input  logic                 rrst_n,
  input  logic                 drain_en,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 tx_timeout,
  fifo_tx_drain_if.master      bus
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("fifo_tx_drain: TIMEOUT_CYC must be at least 1");
  end

  drain_state_t          state_q, state_d;
  logic                  r_inc_q, r_inc_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  pop;
  logic                  expired;

  // Pops only from IDLE, so a lagging rempty can never cause a second pop.
  assign pop = (state_q == IDLE) && drain_en && !bus.rempty && !bus.tx_busy;

`ifdef DRAIN_TIMEOUT_EN
  drain_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .r_clk   (r_clk),
    .rrst_n  (rrst_n),
    .clr     (pop),
    .en      ((state_q == PRESENT) && !bus.tx_busy),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    r_inc_d    = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    word_cnt_d = word_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = bus.rdata;
          r_inc_d    = 1'b1;
          tx_valid_d = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        // Acceptance takes priority over a timeout landing on the same edge.
        if (bus.tx_busy) begin
          tx_valid_d = 1'b0;
          word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
          state_d    = BUSY;
        end else if (expired) begin
          tx_valid_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      BUSY: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      state_q    <= IDLE;
      r_inc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      word_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_inc_q    <= r_inc_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      word_cnt_q <= word_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.r_inc    = r_inc_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign word_cnt     = word_cnt_q;
  assign tx_timeout   = timeout_q;

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Directed bench for fifo_tx_drain: single-edge pop vectors plus multi-cycle sequences.
module tb_fifo_tx_drain;

  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int TMO = 8;

  logic          r_clk;
  logic          rrst_n;
  logic          drain_en;
  logic [CW-1:0] word_cnt;
  logic          tx_timeout;

  fifo_tx_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_tx_drain #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .r_clk      (r_clk),
    .rrst_n     (rrst_n),
    .drain_en   (drain_en),
    .word_cnt   (word_cnt),
    .tx_timeout (tx_timeout),
    .bus        (bus)
  );

  int tests = 0;
  int fails = 0;

  // Source selects: manual drive for the vector table, models for sequences.
  logic          model_on, xmit_on;
  logic          man_rempty, man_busy;
  logic [DW-1:0] man_rdata;

  logic [DW-1:0] fifo_mem [0:31];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic          fifo_empty_r = 1'b1;
  logic [DW-1:0] fifo_head_r  = '0;

  logic          xm_busy = 1'b0;
  int            xm_left = 0;
  logic [DW-1:0] rx_q [$];

  int   pop_cnt   = 0;
  int   busy_viol = 0;
  logic busy_prev = 1'b0;

  assign bus.rempty  = model_on ? fifo_empty_r : man_rempty;
  assign bus.rdata   = model_on ? fifo_head_r  : man_rdata;
  assign bus.tx_busy = xmit_on  ? xm_busy      : man_busy;

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  // FIFO sees r_inc at the edge after it rises; status refreshes at the following negedge.
  always @(posedge r_clk) begin
    if (bus.r_inc === 1'b1) begin
      pop_cnt <= pop_cnt + 1;
      if (busy_prev) busy_viol <= busy_viol + 1;
      if (model_on && (rd_idx < wr_idx)) rd_idx <= rd_idx + 1;
    end
    busy_prev <= (bus.tx_busy === 1'b1);
  end

  always @(negedge r_clk) begin
    fifo_empty_r <= (rd_idx >= wr_idx);
    fifo_head_r  <= fifo_mem[rd_idx % 32];
  end

  // Transmitter: takes a word on tx_valid, stays busy for 10 cycles.
  always @(negedge r_clk) begin
    if (!xmit_on) begin
      xm_busy <= 1'b0;
      xm_left <= 0;
    end else if (xm_left > 0) begin
      xm_left <= xm_left - 1;
      if (xm_left == 1) xm_busy <= 1'b0;
    end else if (bus.tx_valid === 1'b1) begin
      rx_q.push_back(bus.tx_data);
      xm_busy <= 1'b1;
      xm_left <= 10;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  task automatic do_reset();
    drain_en = 1'b0;
    man_busy = 1'b0;
    xmit_on  = 1'b0;
    rrst_n   = 1'b0;
    tick(1);
    rrst_n   = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_mem[wr_idx % 32] = d;
    wr_idx++;
  endtask

  typedef struct {
    logic          en;
    logic          empty;
    logic          busy;
    logic [DW-1:0] data;
    logic          exp_inc;
    logic          exp_vld;
    logic [DW-1:0] exp_dat;
  } vec_t;

  vec_t vecs [6];
  int   p0, rx0;
  logic any_tmo, any_drop;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00};

    model_on   = 1'b0;
    xmit_on    = 1'b0;
    man_rempty = 1'b1;
    man_rdata  = '0;
    man_busy   = 1'b0;
    drain_en   = 1'b0;
    rrst_n     = 1'b0;
    tick(2);
    do_reset();

    chk("rst_r_inc",      32'(bus.r_inc),    32'h0);
    chk("rst_tx_valid",   32'(bus.tx_valid), 32'h0);
    chk("rst_tx_data",    32'(bus.tx_data),  32'h0);
    chk("rst_word_cnt",   32'(word_cnt),     32'h0);
    chk("rst_tx_timeout", 32'(tx_timeout),   32'h0);

    // Single-edge pop decision from IDLE.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      drain_en   = vecs[i].en;
      man_rempty = vecs[i].empty;
      man_busy   = vecs[i].busy;
      man_rdata  = vecs[i].data;
      tick(1);
      chk($sformatf("vec%0d_r_inc", i),    32'(bus.r_inc),    32'(vecs[i].exp_inc));
      chk($sformatf("vec%0d_tx_valid", i), 32'(bus.tx_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_tx_data", i),  32'(bus.tx_data),  32'(vecs[i].exp_dat));
    end

    model_on = 1'b1;

    // Single word, busy held 3 cycles.
    do_reset();
    p0 = pop_cnt;
    push(8'hA5);
    tick(1);
    drain_en = 1'b1;
    tick(1);
    chk("a_r_inc_rise",  32'(bus.r_inc),    32'h1);
    chk("a_tx_data",     32'(bus.tx_data),  32'hA5);
    chk("a_tx_valid",    32'(bus.tx_valid), 32'h1);
    tick(1);
    chk("a_r_inc_fall",  32'(bus.r_inc),    32'h0);
    chk("a_valid_hold",  32'(bus.tx_valid), 32'h1);
    man_busy = 1'b1;
    tick(1);
    chk("a_valid_drop",  32'(bus.tx_valid), 32'h0);
    chk("a_word_cnt",    32'(word_cnt),     32'h1);
    tick(2);
    man_busy = 1'b0;
    tick(3);
    chk("a_pop_count",   32'(pop_cnt - p0), 32'h1);
    chk("a_data_stable", 32'(bus.tx_data),  32'hA5);
    drain_en = 1'b0;

    // Four words through the 10-cycle transmitter model.
    do_reset();
    p0  = pop_cnt;
    rx0 = rx_q.size();
    for (int i = 1; i <= 4; i++) push(8'(i));
    xmit_on = 1'b1;
    tick(1);
    drain_en = 1'b1;
    for (int i = 0; i < 200 && (rx_q.size() - rx0) < 4; i++) tick(1);
    tick(5);
    chk("b_rx_count", 32'(rx_q.size() - rx0), 32'h4);
    for (int i = 0; i < 4; i++) begin
      if (rx0 + i < rx_q.size())
        chk($sformatf("b_word%0d", i), 32'(rx_q[rx0 + i]), 32'(i + 1));
    end
    chk("b_pop_count",  32'(pop_cnt - p0), 32'h4);
    chk("b_word_cnt",   32'(word_cnt),     32'h4);
    drain_en = 1'b0;
    tick(12);
    chk("b_busy_pops",  32'(busy_viol),    32'h0);
    xmit_on = 1'b0;

    // Reset while BUSY, then a clean pop afterwards.
    do_reset();
    push(8'h33);
    push(8'h44);
    tick(1);
    drain_en = 1'b1;
    tick(1);
    drain_en = 1'b0;
    man_busy = 1'b1;
    tick(1);
    rrst_n = 1'b0;
    tick(1);
    chk("d_r_inc",      32'(bus.r_inc),    32'h0);
    chk("d_tx_valid",   32'(bus.tx_valid), 32'h0);
    chk("d_tx_data",    32'(bus.tx_data),  32'h0);
    chk("d_word_cnt",   32'(word_cnt),     32'h0);
    chk("d_tx_timeout", 32'(tx_timeout),   32'h0);
    rrst_n   = 1'b1;
    man_busy = 1'b0;
    drain_en = 1'b1;
    tick(1);
    chk("d_repop_r_inc", 32'(bus.r_inc),   32'h1);
    chk("d_repop_data",  32'(bus.tx_data), 32'h44);
    drain_en = 1'b0;
    man_busy = 1'b1;
    tick(1);
    man_busy = 1'b0;
    tick(2);

    // Counter wrap from all-ones.
    do_reset();
    force dut.word_cnt_q = 16'hFFFF;
    tick(1);
    release dut.word_cnt_q;
    push(8'h55);
    tick(1);
    drain_en = 1'b1;
    tick(1);
    drain_en = 1'b0;
    chk("e_preload",  32'(word_cnt), 32'hFFFF);
    man_busy = 1'b1;
    tick(1);
    chk("e_wrap",     32'(word_cnt), 32'h0);
    man_busy = 1'b0;
    tick(2);

`ifdef DRAIN_TIMEOUT_EN
    // Timeout after 8 unaccepted PRESENT cycles, then acceptance on cycle 8.
    do_reset();
    push(8'h66);
    tick(1);
    drain_en = 1'b1;
    tick(1);
    drain_en = 1'b0;
    tick(7);
    chk("f_valid_c7",   32'(bus.tx_valid), 32'h1);
    chk("f_tmo_c7",     32'(tx_timeout),   32'h0);
    tick(1);
    chk("f_valid_drop", 32'(bus.tx_valid), 32'h0);
    chk("f_tmo_pulse",  32'(tx_timeout),   32'h1);
    chk("f_cnt_same",   32'(word_cnt),     32'h0);
    tick(1);
    chk("f_tmo_single", 32'(tx_timeout),   32'h0);
    chk("f_no_repop",   32'(bus.r_inc),    32'h0);
    push(8'h77);
    tick(1);
    drain_en = 1'b1;
    tick(1);
    drain_en = 1'b0;
    tick(7);
    man_busy = 1'b1;
    tick(1);
    chk("f_acc_valid",  32'(bus.tx_valid), 32'h0);
    chk("f_acc_no_tmo", 32'(tx_timeout),   32'h0);
    chk("f_acc_cnt",    32'(word_cnt),     32'h1);
    man_busy = 1'b0;
    tick(2);
`else
    // Without the timeout the word is held indefinitely.
    do_reset();
    push(8'h88);
    tick(1);
    drain_en = 1'b1;
    tick(1);
    drain_en = 1'b0;
    any_tmo  = 1'b0;
    any_drop = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (tx_timeout !== 1'b0) any_tmo = 1'b1;
      if (bus.tx_valid !== 1'b1) any_drop = 1'b1;
    end
    chk("h_no_timeout", 32'(any_tmo),  32'h0);
    chk("h_valid_held", 32'(any_drop), 32'h0);
    man_busy = 1'b1;
    tick(1);
    chk("h_word_cnt",   32'(word_cnt), 32'h1);
    man_busy = 1'b0;
    tick(2);
`endif

    // drain_en dropped in PRESENT: word completes, nothing further popped.
    do_reset();
    p0 = pop_cnt;
    push(8'h11);
    push(8'h22);
    tick(1);
    drain_en = 1'b1;
    tick(1);
    drain_en = 1'b0;
    tick(2);
    chk("c_valid_held", 32'(bus.tx_valid), 32'h1);
    chk("c_data",       32'(bus.tx_data),  32'h11);
    man_busy = 1'b1;
    tick(1);
    man_busy = 1'b0;
    tick(10);
    chk("c_word_cnt",   32'(word_cnt),     32'h1);
    chk("c_pop_count",  32'(pop_cnt - p0), 32'h1);
    chk("c_fifo_left",  32'(bus.rempty),   32'h0);
    chk("c_valid_idle", 32'(bus.tx_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
